// File: rtl/accel_fifo.sv
// Single-clock FIFO buffering one direction between the bus controller and an accelerator.
// Optional sticky overflow/underflow flags are enabled by defining ACCEL_FIFO_ERR_FLAGS_EN.
module accel_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int CW = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, full_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic              wr_acc, rd_acc;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc   = rd_en & ~empty_q;
        wr_acc   = wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CW'(DEPTH));
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    // Storage is not cleared on reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef ACCEL_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (wr_en & full_q & ~rd_acc);
            underflow_q <= underflow_q | (rd_en & empty_q);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;

endmodule

// File: tb/tb_accel_fifo.sv
// Directed self-checking bench for accel_fifo (16 x 32), error-flag expectations follow ACCEL_FIFO_ERR_FLAGS_EN.
module tb_accel_fifo;

`ifdef ACCEL_FIFO_ERR_FLAGS_EN
    localparam logic [31:0] ERR = 32'd1;
`else
    localparam logic [31:0] ERR = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    accel_fifo #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        rd_en = 1'b1; wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        chk_val(tag, rd_data, exp);
        chk_val({tag, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

        // Reset and idle
        do_reset(2);
        chk_val("rst_empty", 32'(empty), 32'd1);
        chk_val("rst_full", 32'(full), 32'd0);
        chk_val("rst_count", 32'(count), 32'd0);
        chk_val("rst_rd_data", rd_data, 32'd0);
        chk_val("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk_val("rst_ovf", 32'(overflow), 32'd0);
        chk_val("rst_unf", 32'(underflow), 32'd0);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk_val("idle_rd_data", rd_data, 32'd0);
        chk_val("idle_rd_valid", 32'(rd_valid), 32'd0);
        chk_val("idle_unf", 32'(underflow), ERR);
        do_reset(1);
        chk_val("unf_cleared", 32'(underflow), 32'd0);

        // Fill to full
        for (int i = 1; i <= 16; i++) begin
            push(32'(i));
            if (i == 15) chk_val("fill15_full", 32'(full), 32'd0);
        end
        chk_val("fill_full", 32'(full), 32'd1);
        chk_val("fill_count", 32'(count), 32'd16);
        chk_val("fill_empty", 32'(empty), 32'd0);

        // Write while full is dropped
        push(32'hDEADBEEF);
        chk_val("ovf_count", 32'(count), 32'd16);
        chk_val("ovf_full", 32'(full), 32'd1);
        chk_val("ovf_flag", 32'(overflow), ERR);

        // Drain in order
        for (int i = 1; i <= 16; i++) pop_chk($sformatf("drain%0d", i), 32'(i));
        chk_val("drain_empty", 32'(empty), 32'd1);
        chk_val("drain_count", 32'(count), 32'd0);
        step();
        chk_val("hold_rd_valid", 32'(rd_valid), 32'd0);
        chk_val("hold_rd_data", rd_data, 32'h10);
        chk_val("ovf_sticky", 32'(overflow), ERR);

        // Simultaneous read/write while full
        do_reset(1);
        chk_val("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 1; i <= 16; i++) push(32'h20 + 32'(i));
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hA5A5A5A5;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk_val("fullrw_data", rd_data, 32'h21);
        chk_val("fullrw_count", 32'(count), 32'd16);
        chk_val("fullrw_full", 32'(full), 32'd1);
        chk_val("fullrw_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 16; i++) pop_chk($sformatf("fulldrain%0d", i - 1), 32'h20 + 32'(i));
        pop_chk("fulldrain16", 32'hA5A5A5A5);
        chk_val("fulldrain_empty", 32'(empty), 32'd1);

        // Simultaneous read/write while empty
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h00000077;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk_val("emptyrw_count", 32'(count), 32'd1);
        chk_val("emptyrw_rd_valid", 32'(rd_valid), 32'd0);
        chk_val("emptyrw_empty", 32'(empty), 32'd0);
        chk_val("emptyrw_unf", 32'(underflow), ERR);
        pop_chk("emptyrw_pop", 32'h00000077);

        // Pointer wrap-around
        do_reset(1);
        for (int i = 0; i < 10; i++) push(32'h200 + 32'(i));
        for (int i = 0; i < 10; i++) pop_chk($sformatf("wrapa%0d", i), 32'h200 + 32'(i));
        for (int i = 0; i < 12; i++) push(32'h100 + 32'(i));
        chk_val("wrap_count", 32'(count), 32'd12);
        for (int i = 0; i < 12; i++) pop_chk($sformatf("wrapb%0d", i), 32'h100 + 32'(i));
        chk_val("wrap_empty", 32'(empty), 32'd1);

        // Reset mid-operation
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk_val("mid_unf_set", 32'(underflow), ERR);
        for (int i = 0; i < 7; i++) push(32'h300 + 32'(i));
        chk_val("mid_count7", 32'(count), 32'd7);
        do_reset(1);
        chk_val("mid_count", 32'(count), 32'd0);
        chk_val("mid_empty", 32'(empty), 32'd1);
        chk_val("mid_ovf", 32'(overflow), 32'd0);
        chk_val("mid_unf", 32'(underflow), 32'd0);
        push(32'h55555555);
        pop_chk("mid_pop", 32'h55555555);
        chk_val("mid_final_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accel_fifo.md
Name: accel_fifo

Overview:
Synchronous single-clock FIFO that sits between the data bus controller and one accelerator (FFT, FIR or IIR). One instance buffers each direction, so each accelerator has a "to" FIFO and a "from" FIFO. The controller pushes bus words in using its data_to_X strobe, and the accelerator pushes results using data_from_X. The FIFO drives the empty/full flags that the controller uses for routing decisions.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 16, number of entries; must be a power of 2, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request; the upstream data_to_X or data_from_X strobe
wr_data  in  WIDTH  write word
rd_en  in  1  read request from the consumer
rd_data  out  WIDTH  registered read word
rd_valid  out  1  high for one cycle when rd_data was updated by an accepted read
empty  out  1  no entries stored
full  out  1  DEPTH entries stored
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky error flag: write attempted while full (optional feature)
underflow  out  1  sticky error flag: read attempted while empty (optional feature)

Behaviour:
- Reset (reset=1 sampled at posedge clk):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0
  - Reset has priority over all other inputs. Reset mid-operation discards all stored data; memory contents need not be cleared.
- Storage: DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
  - count is kept as a separate ADDR_W+1-bit register.
- Accepted write: wr_acc = wr_en & (~full | rd_acc).
  - mem[wr_ptr] <= wr_data; wr_ptr increments.
- Accepted read: rd_acc = rd_en & ~empty.
  - rd_data <= mem[rd_ptr]; rd_ptr increments; rd_valid=1 on the next cycle.
- Read latency is 1 cycle (no fall-through). rd_data holds its last value when no read is accepted; rd_valid=0 on those cycles.
- Count update each cycle:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
- Flags are registered and derived from the next count: empty = (count_next==0), full = (count_next==DEPTH). Both are valid in the same cycle count changes.
- Simultaneous events:
  - Full with rd_en and wr_en: both accepted, count stays DEPTH, full stays 1, no overflow.
  - Empty with rd_en and wr_en: write accepted, read rejected, count becomes 1, underflow is set (if enabled).
- Write while full without a read: word dropped, pointers unchanged.
- Read while empty: rd_data unchanged, rd_valid=0.
- Data ordering is strictly first-in first-out across pointer wrap-around.

Optional Feature:
Macro ACCEL_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow is set when wr_en=1 & full=1 & ~rd_acc.
  - underflow is set when rd_en=1 & empty=1.
  - Both flags are sticky until reset.
- Not defined: overflow and underflow are tied to 0 and the detection logic is removed. The ports remain so instantiations are identical either way.

Test Plan:
- Reset/idle: assert reset 2 cycles, then deassert -> empty=1, full=0, count=0, rd_data=0, rd_valid=0; an rd_en pulse leaves rd_data=0.
- Fill/drain: write 0x00000001..0x00000010 on 16 consecutive cycles -> full=1 and count=16 after the 16th edge. Then read 16 cycles -> rd_data returns 0x1..0x10 in order, each one cycle after its rd_en; empty=1 after the last read.
- Overflow: with FIFO full, write 0xDEADBEEF -> count stays 16; a later drain never returns 0xDEADBEEF; overflow=1 with the macro, 0 without.
- Simultaneous at boundaries:
  - Full with rd_en=wr_en=1 and wr_data 0xA5A5A5A5 -> count=16, first word popped; 0xA5A5A5A5 appears as the 16th read of the subsequent drain.
  - Empty with both asserted -> count=1, rd_valid=0, underflow=1 with the macro.
- Wrap-around: write 10, read 10, then write 12 (0x100..0x10B) and read 12 -> data in order, with pointers crossing index 15->0 correctly.
- Reset mid-operation: with count=7, assert reset for one cycle -> count=0, empty=1, sticky flags cleared. The next write/read of 0x55555555 returns 0x55555555.
